int_to_ieee: RTL and testbench

Sequential converter from a 32-bit integer to an IEEE-754 single-precision word. It is the operand producer for `IEEE_adder`: its output drives `number1`/`number2` directly. Normalisation is iterative, one left shift per clock, followed by a single round-to-nearest-even stage. Valid/ready handshakes sit on both the input side and the output side.

---
 rtl/ieee_pkg.sv | 24 ++
 rtl/int_to_ieee_if.sv | 25 ++
 rtl/ieee_round_rne.sv | 34 +++
 rtl/int_to_ieee.sv | 110 +++++++++++
 tb/tb_int_to_ieee.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/ieee_pkg.sv
// Shared IEEE-754 single-precision definitions.
// Used by int_to_ieee, ieee_round_rne and IEEE_adder.
//   i2f_state_t : int_to_ieee FSM states
//   ieee_sp_t   : packed {sign, exp, frac} single-precision word
package ieee_pkg;

   localparam int unsigned EXP_BIAS = 127;
   localparam int unsigned FRAC_W   = 23;
   localparam int unsigned EXP_W    = 8;

   typedef enum logic [1:0] {
      IDLE,
      NORM,
      ROUND,
      DONE
   } i2f_state_t;

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exp;
      logic [FRAC_W-1:0] frac;
   } ieee_sp_t;

endpackage

// File: rtl/int_to_ieee_if.sv
// Handshake bundle for int_to_ieee.
//   in_valid / in_ready / in_int                  : operand side
//   out_valid / out_ready / out_float / out_inexact : result side
// master = producer/consumer around the converter, slave = converter.
interface int_to_ieee_if;

   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_int;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_float;
   logic        out_inexact;

   modport master (
      output in_valid, in_int, out_ready,
      input  in_ready, out_valid, out_float, out_inexact
   );

   modport slave (
      input  in_valid, in_int, out_ready,
      output in_ready, out_valid, out_float, out_inexact
   );

endinterface

// File: rtl/ieee_round_rne.sv
// Combinational round-to-nearest-even of a normalised mantissa.
//   frac_i    : 23-bit fraction (hidden bit excluded)
//   guard_i   : first discarded bit
//   sticky_i  : OR of all remaining discarded bits
//   exp_i     : biased exponent before rounding
//   frac_o    : rounded fraction
//   exp_o     : exponent, incremented when the mantissa overflows
//   inexact_o : any discarded bit was non-zero
module ieee_round_rne
   import ieee_pkg::*;
(
   input  logic [FRAC_W-1:0] frac_i,
   input  logic              guard_i,
   input  logic              sticky_i,
   input  logic [EXP_W-1:0]  exp_i,
   output logic [FRAC_W-1:0] frac_o,
   output logic [EXP_W-1:0]  exp_o,
   output logic              inexact_o
);

   logic            round_up;
   logic [FRAC_W:0] sum;

   always_comb begin
      // Ties go to the even neighbour: only round up on a tie if LSB is odd.
      round_up  = guard_i & (sticky_i | frac_i[0]);
      sum       = {1'b0, frac_i} + {{FRAC_W{1'b0}}, round_up};
      frac_o    = sum[FRAC_W-1:0];
      // Carry out means 1.111..1 rounded to 10.000..0: bump the exponent.
      exp_o     = exp_i + {{(EXP_W-1){1'b0}}, sum[FRAC_W]};
      inexact_o = guard_i | sticky_i;
   end

endmodule

// File: rtl/int_to_ieee.sv
// Sequential 32-bit integer to IEEE-754 single converter.
// Iterative normalisation (one left shift per clock) then one RNE stage.
//   clk  : clock, rising edge
//   rstn : asynchronous active-low reset
//   bus  : int_to_ieee_if.slave handshake bundle (input and output sides)
//   SIGNED = 1 treats in_int as two's complement, 0 as unsigned.
module int_to_ieee
   import ieee_pkg::*;
#(
   parameter bit SIGNED = 1'b1
) (
   input  logic         clk,
   input  logic         rstn,
   int_to_ieee_if.slave bus
);

   i2f_state_t  state_q;
   logic [31:0] mag_q;
   logic [4:0]  exp_cnt_q;
   logic        sign_q;
   logic        in_ready_q;
   logic        out_valid_q;
   ieee_sp_t    out_float_q;
   logic        out_inexact_q;

   logic              in_neg_d;
   logic [31:0]       in_mag_d;
   logic [EXP_W-1:0]  exp_biased_d;
   logic [FRAC_W-1:0] frac_rnd;
   logic [EXP_W-1:0]  exp_rnd;
   logic              inexact_rnd;

   always_comb begin
      in_neg_d     = SIGNED & bus.in_int[31];
      in_mag_d     = in_neg_d ? (~bus.in_int + 32'd1) : bus.in_int;
      exp_biased_d = {3'b000, exp_cnt_q} + EXP_W'(EXP_BIAS);
   end

   ieee_round_rne u_round (
      .frac_i    (mag_q[30:8]),
      .guard_i   (mag_q[7]),
      .sticky_i  (|mag_q[6:0]),
      .exp_i     (exp_biased_d),
      .frac_o    (frac_rnd),
      .exp_o     (exp_rnd),
      .inexact_o (inexact_rnd)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q       <= IDLE;
         mag_q         <= '0;
         exp_cnt_q     <= '0;
         sign_q        <= 1'b0;
         in_ready_q    <= 1'b0;
         out_valid_q   <= 1'b0;
         out_float_q   <= '0;
         out_inexact_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (!in_ready_q) begin
                  in_ready_q <= 1'b1;
               end else if (bus.in_valid) begin
                  in_ready_q <= 1'b0;
                  sign_q     <= in_neg_d;
                  mag_q      <= in_mag_d;
                  exp_cnt_q  <= 5'd31;
                  // Zero skips NORM and passes through ROUND, which forces a
                  // zero word when mag[31] is clear; gives the 1-cycle latency.
                  state_q    <= (in_mag_d == '0) ? ROUND : NORM;
               end
            end
            NORM: begin
               if (mag_q[31]) begin
                  state_q <= ROUND;
               end else begin
                  mag_q     <= mag_q << 1;
                  exp_cnt_q <= exp_cnt_q - 5'd1;
               end
            end
            ROUND: begin
               if (mag_q[31]) begin
                  out_float_q   <= {sign_q, exp_rnd, frac_rnd};
                  out_inexact_q <= inexact_rnd;
               end else begin
                  out_float_q   <= '0;
                  out_inexact_q <= 1'b0;
               end
               out_valid_q <= 1'b1;
               state_q     <= DONE;
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.in_ready    = in_ready_q;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_float   = out_float_q;
   assign bus.out_inexact = out_inexact_q;

endmodule

// File: tb/tb_int_to_ieee.sv
// Self-checking bench for int_to_ieee. A signed and an unsigned instance
// receive identical stimulus; results, inexact flags and latencies are
// compared against an arithmetic reference model.
module tb_int_to_ieee;

   logic        clk;
   logic        rstn;
   logic        in_valid;
   logic [31:0] in_int;
   logic        out_ready;

   int n_cmp = 0;
   int n_err = 0;

   int_to_ieee_if bus_s ();
   int_to_ieee_if bus_u ();

   assign bus_s.in_valid  = in_valid;
   assign bus_s.in_int    = in_int;
   assign bus_s.out_ready = out_ready;
   assign bus_u.in_valid  = in_valid;
   assign bus_u.in_int    = in_int;
   assign bus_u.out_ready = out_ready;

   int_to_ieee #(.SIGNED(1'b1)) dut_s (.clk(clk), .rstn(rstn), .bus(bus_s));
   int_to_ieee #(.SIGNED(1'b0)) dut_u (.clk(clk), .rstn(rstn), .bus(bus_u));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
      n_cmp++;
      if (act !== exp_v) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp_v);
      end
   endtask

   // Reference: find the leading one, divide down to 24 significant bits,
   // round the remainder to nearest-even.
   function automatic void ref_model(input logic [31:0] v, input bit sgn,
                                     output logic [31:0] f, output bit inex,
                                     output int lat);
      longint unsigned mag, q, rem, half;
      int p, sh;
      bit s;
      s   = sgn && v[31];
      mag = s ? (64'd4294967296 - {32'd0, v}) : {32'd0, v};
      f    = '0;
      inex = 1'b0;
      lat  = 1;
      if (mag == 0) return;
      p = 0;
      for (int b = 0; b < 32; b++) if (mag[b]) p = b;
      lat = (31 - p) + 2;
      if (p <= 23) begin
         q = mag << (23 - p);
      end else begin
         sh   = p - 23;
         q    = mag >> sh;
         rem  = mag - (q << sh);
         half = 64'd1 << (sh - 1);
         inex = (rem != 0);
         if (rem > half || (rem == half && q[0])) q++;
         if (q == (64'd1 << 24)) begin
            q = q >> 1;
            p++;
         end
      end
      f = {s, 8'(p + 127), q[22:0]};
   endfunction

   task automatic convert(input logic [31:0] v, input int unsigned hold);
      logic [31:0] ef_s, ef_u;
      bit ei_s, ei_u, rdy;
      int el_s, el_u, lat_s, lat_u;
      ref_model(v, 1'b1, ef_s, ei_s, el_s);
      ref_model(v, 1'b0, ef_u, ei_u, el_u);
      rdy = 1'b0;
      for (int i = 0; i < 50 && !rdy; i++) begin
         @(negedge clk);
         rdy = bus_s.in_ready && bus_u.in_ready;
      end
      check("accept_ready", {31'd0, rdy}, 32'd1);
      if (!rdy) return;
      in_int   = v;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_int   = $urandom;
      lat_s = -1;
      lat_u = -1;
      for (int c = 0; c < 40 && (lat_s < 0 || lat_u < 0); c++) begin
         @(negedge clk);
         if (c == 0) check("busy_in_ready", {30'd0, bus_s.in_ready, bus_u.in_ready}, 32'd0);
         if (lat_s < 0 && bus_s.out_valid) lat_s = c;
         if (lat_u < 0 && bus_u.out_valid) lat_u = c;
         // in_valid while busy must be ignored
         in_valid = 1'($urandom_range(0, 1));
         in_int   = $urandom;
      end
      check("lat_s", lat_s, el_s);
      check("lat_u", lat_u, el_u);
      check("float_s", bus_s.out_float, ef_s);
      check("float_u", bus_u.out_float, ef_u);
      check("inexact_s", {31'd0, bus_s.out_inexact}, {31'd0, ei_s});
      check("inexact_u", {31'd0, bus_u.out_inexact}, {31'd0, ei_u});
      for (int h = 0; h < int'(hold); h++) begin
         @(negedge clk);
         in_valid = 1'($urandom_range(0, 1));
         check("hold_float_s", bus_s.out_float, ef_s);
         check("hold_inexact_s", {31'd0, bus_s.out_inexact}, {31'd0, ei_s});
         check("hold_valid", {30'd0, bus_s.out_valid, bus_u.out_valid}, 32'd3);
         check("hold_in_ready", {30'd0, bus_s.in_ready, bus_u.in_ready}, 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      check("valid_drop", {30'd0, bus_s.out_valid, bus_u.out_valid}, 32'd0);
      check("ready_back", {30'd0, bus_s.in_ready, bus_u.in_ready}, 32'd3);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_float_s"}, bus_s.out_float, 32'd0);
      check({tag, "_float_u"}, bus_u.out_float, 32'd0);
      check({tag, "_flags"}, {28'd0, bus_s.out_valid, bus_u.out_valid,
                               bus_s.out_inexact, bus_u.out_inexact}, 32'd0);
      check({tag, "_in_ready"}, {30'd0, bus_s.in_ready, bus_u.in_ready}, 32'd0);
   endtask

   initial begin
      rstn      = 1'b0;
      in_valid  = 1'b0;
      in_int    = '0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("rst");
      rstn = 1'b1;
      check("rst_ready_low", {30'd0, bus_s.in_ready, bus_u.in_ready}, 32'd0);
      @(posedge clk);
      #1;
      check("rst_ready_rise", {30'd0, bus_s.in_ready, bus_u.in_ready}, 32'd3);

      convert(32'd7, 0);
      convert(32'hFFFF_FFFB, 0);
      convert(32'h8000_0000, 0);
      convert(32'd0, 0);
      convert(32'd16777217, 0);
      convert(32'd16777219, 0);
      convert(32'h7FFF_FFFF, 0);
      convert(32'hFFFF_FFFF, 0);
      convert(32'd12345678, 5);
      for (int n = 0; n < 40; n++) begin
         convert($urandom >> $urandom_range(0, 31), $urandom_range(0, 3));
      end
      convert(32'd33554431, 1);

      // Reset while the converter is shifting through NORM
      @(negedge clk);
      in_int   = 32'd7;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rstn = 1'b0;
      #2;
      check_reset_outputs("midrst");
      @(negedge clk);
      rstn = 1'b1;
      check("midrst_ready_low", {30'd0, bus_s.in_ready, bus_u.in_ready}, 32'd0);
      @(posedge clk);
      #1;
      check("midrst_ready_rise", {30'd0, bus_s.in_ready, bus_u.in_ready}, 32'd3);
      convert(32'd1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
